// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI master scheduler.
// Holds the FSM state encoding and the layout of the per-requester config word.
package spi_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  localparam int CFG_W        = 32;
  localparam int CFG_USED_W   = 19;
  localparam int CFG_LEN_LSB  = 0;
  localparam int CFG_LEN_W    = 4;
  localparam int CFG_CS_LSB   = 4;
  localparam int CFG_CS_W     = 4;
  localparam int CFG_DIV_LSB  = 8;
  localparam int CFG_DIV_W    = 8;
  localparam int CFG_CPOL_BIT = 16;
  localparam int CFG_CPHA_BIT = 17;
  localparam int CFG_LSB_BIT  = 18;

  localparam logic [3:0] M_LENGTH_RST = 4'hF;

  typedef struct packed {
    logic                 lsb_first;
    logic                 cpha;
    logic                 cpol;
    logic [CFG_DIV_W-1:0] clk_div;
    logic [CFG_CS_W-1:0]  cs;
    logic [CFG_LEN_W-1:0] length;
  } cfg_t;

  // Only the defined low bits are passed in; the reserved field never reaches the master.
  function automatic cfg_t cfg_fields(input logic [CFG_USED_W-1:0] bits);
    cfg_t c;
    c.length    = bits[CFG_LEN_LSB +: CFG_LEN_W];
    c.cs        = bits[CFG_CS_LSB +: CFG_CS_W];
    c.clk_div   = bits[CFG_DIV_LSB +: CFG_DIV_W];
    c.cpol      = bits[CFG_CPOL_BIT];
    c.cpha      = bits[CFG_CPHA_BIT];
    c.lsb_first = bits[CFG_LSB_BIT];
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above the pointer, with wrap.
// The pointer moves to one past the finished owner when advance is pulsed.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [IDX_W-1:0] owner,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int SW = IDX_W + 1;

  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [SW-1:0]    sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
    end
  end

  // Rotating the doubled vector puts the pointer position at bit 0, so the lowest hit wins.
  always_comb begin
    rot       = N'({req, req} >> ptr);
    gnt_valid = 1'b0;
    off       = '0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_valid && rot[k]) begin
        gnt_valid = 1'b1;
        off       = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    gnt_idx = sum[IDX_W-1:0];
    gnt     = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = gnt_valid && (gnt_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/spi_master_sched.sv
// Shares one SPI master core between N_REQ requesters with round-robin arbitration.
// Each grant loads the owner's config, starts one transfer and returns MISO data with done/err.
module spi_master_sched
  import spi_sched_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int DATA_W  = 16,
  parameter int CS_W    = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*CFG_W-1:0]  req_cfg,
  input  logic [N_REQ*DATA_W-1:0] req_tx,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic [DATA_W-1:0]       rx_data,
  output logic [3:0]              m_length,
  output logic [CS_W-1:0]         m_cs,
  output logic [7:0]              m_clk_div,
  output logic                    m_cpol,
  output logic                    m_cpha,
  output logic                    m_lsb_first,
  output logic                    m_start,
  output logic [DATA_W-1:0]       m_mosi,
  input  logic                    m_writable,
  input  logic                    m_idle,
  input  logic [DATA_W-1:0]       m_miso
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_t state, state_n;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [IDX_W-1:0]  owner_idx;

  logic [CFG_W-1:0]  sel_cfg;
  logic [DATA_W-1:0] sel_tx;
  logic              cfg_reserved_unused;
  cfg_t              cfg_lat;
  logic [DATA_W-1:0] tx_lat;

  logic [TW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic              counting;

  logic latch_en, load_en, start_n, finish, finish_err;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .req       (req),
    .advance   (state == S_DONE),
    .owner     (owner_idx),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    sel_cfg = '0;
    sel_tx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_cfg = req_cfg[i*CFG_W +: CFG_W];
        sel_tx  = req_tx[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cfg_reserved_unused = ^sel_cfg[CFG_W-1:CFG_USED_W];

  assign counting = (state == S_ARM) || (state == S_WAIT_BUSY) || (state == S_WAIT_IDLE);
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A start that coincides with the last timeout cycle still wins over the abort.
  always_comb begin
    state_n    = state;
    latch_en   = 1'b0;
    load_en    = 1'b0;
    start_n    = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_valid) begin
          latch_en = 1'b1;
          state_n  = S_LOAD;
        end
      end
      S_LOAD: begin
        load_en = 1'b1;
        state_n = S_ARM;
      end
      S_ARM: begin
        if (m_writable) begin
          start_n = 1'b1;
          state_n = S_WAIT_BUSY;
        end else if (tmo_hit) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_n    = S_DONE;
        end
      end
      S_WAIT_BUSY: begin
        if (!m_idle) begin
          state_n = S_WAIT_IDLE;
        end else if (tmo_hit) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_n    = S_DONE;
        end
      end
      S_WAIT_IDLE: begin
        if (m_idle) begin
          finish  = 1'b1;
          state_n = S_DONE;
        end else if (tmo_hit) begin
          finish     = 1'b1;
          finish_err = 1'b1;
          state_n    = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tmo_cnt <= '0;
    end else if (state_n != state) begin
      tmo_cnt <= '0;
    end else if (counting) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Master-facing config only changes in LOAD, so it stays stable for the whole transfer.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      grant       <= '0;
      owner_idx   <= '0;
      cfg_lat     <= '0;
      tx_lat      <= '0;
      m_length    <= M_LENGTH_RST;
      m_cs        <= '0;
      m_clk_div   <= '0;
      m_cpol      <= 1'b0;
      m_cpha      <= 1'b0;
      m_lsb_first <= 1'b0;
      m_mosi      <= '0;
      m_start     <= 1'b0;
      done        <= '0;
      err         <= 1'b0;
      rx_data     <= '0;
    end else begin
      m_start <= start_n;
      done    <= finish ? grant : '0;
      if (latch_en) begin
        grant     <= arb_gnt;
        owner_idx <= arb_idx;
        cfg_lat   <= cfg_fields(sel_cfg[CFG_USED_W-1:0]);
        tx_lat    <= sel_tx;
      end else if (state == S_DONE) begin
        grant <= '0;
      end
      if (load_en) begin
        m_length    <= cfg_lat.length;
        m_cs        <= CS_W'(cfg_lat.cs);
        m_clk_div   <= cfg_lat.clk_div;
        m_cpol      <= cfg_lat.cpol;
        m_cpha      <= cfg_lat.cpha;
        m_lsb_first <= cfg_lat.lsb_first;
        m_mosi      <= tx_lat;
      end
      if (finish) begin
        err     <= finish_err;
        rx_data <= finish_err ? '0 : m_miso;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched with a simple echoing SPI master model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spi_master_sched;

  localparam int N_REQ         = 3;
  localparam int DATA_W        = 16;
  localparam int CS_W          = 4;
  localparam int TIMEOUT       = 100;
  localparam int MASTER_CYCLES = 4;

  // Requester 0: len F, cs 1, div 4. Requester 1: len 7, cs 2, div 2, cpol.
  // Requester 2: len B, cs 4, div 8, cpha, lsb_first.
  localparam logic [31:0] CFG0 = 32'h0000_041F;
  localparam logic [31:0] CFG1 = 32'h0001_0227;
  localparam logic [31:0] CFG2 = 32'h0006_084B;
  localparam logic [15:0] TX0  = 16'haa55;
  localparam logic [15:0] TX1  = 16'h1234;
  localparam logic [15:0] TX2  = 16'hc3f0;

  logic                    sys_clk = 1'b0;
  logic                    sys_rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*32-1:0]     req_cfg;
  logic [N_REQ*DATA_W-1:0] req_tx;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    err;
  logic [DATA_W-1:0]       rx_data;
  logic [3:0]              m_length;
  logic [CS_W-1:0]         m_cs;
  logic [7:0]              m_clk_div;
  logic                    m_cpol, m_cpha, m_lsb_first;
  logic                    m_start;
  logic [DATA_W-1:0]       m_mosi;
  logic                    m_writable;
  logic                    m_idle;
  logic [DATA_W-1:0]       m_miso = '0;

  logic              wr_en = 1'b0;
  logic              busy = 1'b0;
  int                busy_cnt = 0;
  logic [DATA_W-1:0] shadow = '0;
  int                start_cnt = 0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] tx_tab [3];

  spi_master_sched #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .CS_W    (CS_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .req         (req),
    .req_cfg     (req_cfg),
    .req_tx      (req_tx),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .rx_data     (rx_data),
    .m_length    (m_length),
    .m_cs        (m_cs),
    .m_clk_div   (m_clk_div),
    .m_cpol      (m_cpol),
    .m_cpha      (m_cpha),
    .m_lsb_first (m_lsb_first),
    .m_start     (m_start),
    .m_mosi      (m_mosi),
    .m_writable  (m_writable),
    .m_idle      (m_idle),
    .m_miso      (m_miso)
  );

  always #5 sys_clk = ~sys_clk;

  // Echoing master: busy for MASTER_CYCLES after a start, ignores sys_rst.
  assign m_writable = wr_en & ~busy;
  assign m_idle     = ~busy;

  always @(posedge sys_clk) begin
    if (m_start) start_cnt <= start_cnt + 1;
    if (busy) begin
      if (busy_cnt == 1) begin
        busy   <= 1'b0;
        m_miso <= shadow;
      end
      busy_cnt <= busy_cnt - 1;
    end else if (m_start) begin
      busy     <= 1'b1;
      busy_cnt <= MASTER_CYCLES;
      shadow   <= m_mosi;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r);
    req = r;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic waitDone(input int limit, output logic [N_REQ-1:0] seen, output int cycles);
    seen   = '0;
    cycles = 0;
    while (cycles < limit && seen == '0) begin
      @(negedge sys_clk);
      cycles++;
      seen = done;
    end
    checkOutput("done_within_bound", 32'(seen != '0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N_REQ-1:0] seen;
    int               cyc;
    int               s0;

    tx_tab[0] = TX0;
    tx_tab[1] = TX1;
    tx_tab[2] = TX2;
    req_cfg   = {CFG2, CFG1, CFG0};
    req_tx    = {TX2, TX1, TX0};
    req       = '0;
    sys_rst   = 1'b1;

    waitCycles(2);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_m_start", 32'(m_start), 32'd0);
    checkOutput("rst_m_length", 32'(m_length), 32'hF);
    checkOutput("rst_m_cs", 32'(m_cs), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    sys_rst = 1'b0;
    waitCycles(1);

    $display("[TB] single request, start held off by m_writable");
    applyStimulus(3'b001);
    s0 = start_cnt;
    waitCycles(3);
    checkOutput("t1_grant", 32'(grant), 32'b001);
    checkOutput("t1_m_length", 32'(m_length), 32'hF);
    checkOutput("t1_m_cs", 32'(m_cs), 32'h1);
    checkOutput("t1_m_clk_div", 32'(m_clk_div), 32'h4);
    checkOutput("t1_m_cpol", 32'(m_cpol), 32'd0);
    checkOutput("t1_m_mosi", 32'(m_mosi), 32'haa55);
    checkOutput("t1_no_start_yet", 32'(m_start), 32'd0);
    wr_en = 1'b1;
    waitCycles(1);
    checkOutput("t1_start_high", 32'(m_start), 32'd1);
    waitCycles(1);
    checkOutput("t1_start_one_cycle", 32'(m_start), 32'd0);
    waitDone(20, seen, cyc);
    checkOutput("t1_done", 32'(seen), 32'b001);
    checkOutput("t1_err", 32'(err), 32'd0);
    checkOutput("t1_rx_data", 32'(rx_data), 32'haa55);
    checkOutput("t1_start_count", 32'(start_cnt - s0), 32'd1);
    applyStimulus(3'b000);
    waitCycles(1);
    checkOutput("t1_done_clear", 32'(done), 32'd0);
    checkOutput("t1_grant_clear", 32'(grant), 32'd0);

    $display("[TB] all requests held, round-robin order");
    sys_rst = 1'b1;
    waitCycles(1);
    sys_rst = 1'b0;
    applyStimulus(3'b111);
    for (int i = 0; i < 6; i++) begin
      waitDone(30, seen, cyc);
      checkOutput("rr_done", 32'(seen), 32'(1 << (i % 3)));
      checkOutput("rr_rx_data", 32'(rx_data), 32'(tx_tab[i % 3]));
      if (i == 0) checkOutput("rr_first_latency", 32'(cyc), 32'd9);
      if (i == 5) applyStimulus(3'b000);
      waitCycles(1);
      checkOutput("rr_idle_gap_grant", 32'(grant), 32'd0);
      checkOutput("rr_done_once", 32'(done), 32'd0);
      if (i < 5) begin
        waitCycles(1);
        checkOutput("rr_next_grant", 32'(grant), 32'(1 << ((i + 1) % 3)));
      end
    end

    $display("[TB] fairness after serving requester 1");
    applyStimulus(3'b010);
    waitDone(30, seen, cyc);
    checkOutput("fair_first_1", 32'(seen), 32'b010);
    applyStimulus(3'b110);
    waitDone(30, seen, cyc);
    checkOutput("fair_then_2", 32'(seen), 32'b100);
    applyStimulus(3'b010);
    waitDone(30, seen, cyc);
    checkOutput("fair_then_1", 32'(seen), 32'b010);
    applyStimulus(3'b000);
    waitCycles(1);

    $display("[TB] timeout in ARM");
    wr_en = 1'b0;
    s0 = start_cnt;
    applyStimulus(3'b001);
    waitDone(150, seen, cyc);
    checkOutput("tmo_done", 32'(seen), 32'b001);
    checkOutput("tmo_latency", 32'(cyc), 32'd102);
    checkOutput("tmo_err", 32'(err), 32'd1);
    checkOutput("tmo_rx_zero", 32'(rx_data), 32'd0);
    checkOutput("tmo_no_start", 32'(start_cnt - s0), 32'd0);
    applyStimulus(3'b000);
    wr_en = 1'b1;
    waitCycles(1);

    $display("[TB] request dropped while waiting for idle");
    applyStimulus(3'b001);
    waitCycles(5);
    checkOutput("drop_grant", 32'(grant), 32'b001);
    applyStimulus(3'b100);
    waitDone(30, seen, cyc);
    checkOutput("drop_done_0", 32'(seen), 32'b001);
    checkOutput("drop_rx_0", 32'(rx_data), 32'haa55);
    checkOutput("drop_err_0", 32'(err), 32'd0);
    waitDone(30, seen, cyc);
    checkOutput("drop_next_2", 32'(seen), 32'b100);
    checkOutput("drop_rx_2", 32'(rx_data), 32'hc3f0);
    applyStimulus(3'b000);
    waitCycles(1);

    $display("[TB] reset while waiting for idle");
    applyStimulus(3'b100);
    waitCycles(5);
    checkOutput("rst_mid_grant", 32'(grant), 32'b100);
    checkOutput("rst_mid_m_length", 32'(m_length), 32'hB);
    checkOutput("rst_mid_m_cs", 32'(m_cs), 32'h4);
    checkOutput("rst_mid_m_clk_div", 32'(m_clk_div), 32'h8);
    checkOutput("rst_mid_m_cpha", 32'(m_cpha), 32'd1);
    checkOutput("rst_mid_m_lsb", 32'(m_lsb_first), 32'd1);
    checkOutput("rst_mid_m_cpol", 32'(m_cpol), 32'd0);
    sys_rst = 1'b1;
    applyStimulus(3'b000);
    #1;
    checkOutput("rst_async_grant", 32'(grant), 32'd0);
    checkOutput("rst_async_m_start", 32'(m_start), 32'd0);
    checkOutput("rst_async_m_length", 32'(m_length), 32'hF);
    checkOutput("rst_async_rx", 32'(rx_data), 32'd0);
    waitCycles(1);
    sys_rst = 1'b0;
    applyStimulus(3'b100);
    waitDone(40, seen, cyc);
    checkOutput("post_rst_done", 32'(seen), 32'b100);
    checkOutput("post_rst_err", 32'(err), 32'd0);
    checkOutput("post_rst_rx", 32'(rx_data), 32'hc3f0);
    applyStimulus(3'b000);
    waitCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
